instruction_fetch: RTL
======================

# instruction_fetch

Instruction-fetch stage and IF/ID pipeline register feeding `instruction_decoder`. Holds the PC, reads the combinational-read instruction memory, and registers the fetched word plus its PC for decode. Honours hazard-unit stalls and EX-stage branch redirects. Detects the all-zero end-of-program word, then drains the pipe with NOPs and reports `done`.

## Interface
- `PC_W`, 32: PC width.
- `IMEM_AW`, 8: instruction memory word-address width.
- `DRAIN_CYCLES`, 4: NOP cycles issued after end-of-program before `done`; range 1..15.
- `NOP_INSTR`, 32'hF000_0000: bubble word, opcode 6'b111100.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin fetching; sampled only in IDLE.
- `stall` in 1: from the hazard detection unit; freezes PC and IF/ID.
- `branch_taken` in 1: EX-stage redirect; the VBNZ/VBENZ condition is resolved upstream of this block.
- `branch_target` in PC_W: absolute word address of the redirect.
- `imem_addr` out IMEM_AW: `pc[IMEM_AW-1:0]`, combinational.
- `imem_data` in 32: instruction at `imem_addr`, same cycle.
- `if_id_instr` out 32: registered instruction to the decoder.
- `if_id_pc` out PC_W: PC of `if_id_instr`.
- `if_id_valid` out 1: 1 = real instruction, 0 = bubble.
- `pc` out PC_W: current fetch PC.
- `done` out 1: program finished and pipe drained.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values:
  - `pc=0`, state IDLE, drain counter 0.
  - `if_id_instr=NOP_INSTR`, `if_id_pc=0`, `if_id_valid=0`, `done=0`.
- IDLE:
  - IF/ID holds the NOP; `pc` holds.
  - `start=1` moves to RUN next cycle. No fetch is registered in the `start` cycle.
- RUN, priority is `branch_taken` > `stall` > end-of-program > normal:
  - `branch_taken`: `pc<=branch_target`; IF/ID<=NOP with valid 0, so the wrong-path word is flushed.
  - `stall`: `pc`, `if_id_instr`, `if_id_pc` and `if_id_valid` all hold.
  - `imem_data==0`: IF/ID<=NOP with valid 0; `pc` holds; go to DRAIN with counter `DRAIN_CYCLES-1`.
  - Normal: `if_id_instr<=imem_data`, `if_id_pc<=pc`, `if_id_valid<=1`, `pc<=pc+1`.
- DRAIN:
  - IF/ID<=NOP with valid 0; `stall` is ignored.
  - `branch_taken` (from an older in-flight branch) returns to RUN: `pc<=branch_target`, counter cleared.
  - Otherwise, counter==0 moves to DONE; else counter decrements.
- DONE:
  - `done=1`, held until `reset`.
  - IF/ID NOP; `pc` holds; all inputs except `reset` are ignored.
- Arithmetic:
  - `pc+1` wraps modulo 2^PC_W.
  - `imem_addr` truncates `pc`, so the fetch address aliases modulo 2^IMEM_AW.
  - `branch_target` is used unmodified.
- `start` is ignored outside IDLE.
- `reset` has absolute priority in every state, including mid-stall and mid-drain.

## Timing
- Fetch-to-decode latency: 1 cycle. The word at `pc` in cycle n appears on `if_id_instr` in cycle n+1.
- Branch penalty: one bubble from this block. `branch_taken` in cycle n gives NOP in n+1 and the target instruction in n+2.
- Stall is level-sensitive; a stall held k cycles repeats the same IF/ID contents k extra cycles.
- Simultaneous `stall` and `branch_taken`: the branch wins.
- Simultaneous `branch_taken` and an end-marker `imem_data`: the branch wins and the marker is discarded.
- `done` rises DRAIN_CYCLES+1 cycles after the cycle in which the end marker was on `imem_data`.

## Structure
- Shared package, common with the decoder:
  - `NOP_INSTR` and the opcode constants (R-type 6'b101010, VBNZ 6'b100010, VBENZ 6'b100011, LD 6'b100000, SD 6'b100001, NOP 6'b111100).
  - Fetch state enum.
- One sub-module, `fetch_pc`: PC register with the next-PC mux (hold / +1 / target) and wrap.
- FSM, drain counter and IF/ID register live in `instruction_fetch`.

## Test plan
- Sequential fetch:
  - Stimulus: reset, `start`, imem[0..3]=A,B,C,D with imem[4]=0.
  - Required: `if_id_instr` A,B,C,D on consecutive cycles with `if_id_pc` 0..3 and valid 1, then NOP ×4 with valid 0, then `done=1`.
- Stall:
  - Stimulus: `stall` asserted for 2 cycles while B is in IF/ID.
  - Required: B and `pc`=2 are held for 3 total cycles; C follows with no loss or duplication.
- Branch:
  - Stimulus: `branch_taken=1`, `branch_target`=0x20 while `pc`=3.
  - Required: next cycle NOP with valid 0; the cycle after, imem[0x20] with `if_id_pc`=0x20.
- Branch vs stall:
  - Stimulus: both asserted in the same cycle.
  - Required: redirect occurs and the flush bubble is inserted, identical to the branch-only case.
- Branch during drain:
  - Stimulus: `branch_taken` 2 cycles after the end marker.
  - Required: returns to RUN at the target; `done` stays 0.
- Reset mid-stall and wrap:
  - Stimulus: `reset` while `stall=1`.
  - Required: all outputs at reset values next cycle.
  - Stimulus: with `PC_W=8`, fetch from `pc`=0xFF.
  - Required: next `pc`=0x00.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch_pkg
// Brief  : Constants and types shared between the fetch stage and the
//          instruction decoder. Provides the bubble word, the opcode
//          encodings, the fetch FSM state encoding and the PC-mux select.
// Rev    : 1.0  initial release
// ============================================================================
package instruction_fetch_pkg;

  // Bubble word injected into IF/ID; its opcode field is OPC_NOP.
  localparam logic [31:0] NOP_INSTR = 32'hF000_0000;

  // Opcode field encodings (bits [31:26] of an instruction word).
  localparam logic [5:0] OPC_RTYPE = 6'b101010;
  localparam logic [5:0] OPC_VBNZ  = 6'b100010;
  localparam logic [5:0] OPC_VBENZ = 6'b100011;
  localparam logic [5:0] OPC_LD    = 6'b100000;
  localparam logic [5:0] OPC_SD    = 6'b100001;
  localparam logic [5:0] OPC_NOP   = 6'b111100;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_DONE  = 2'd3
  } fetch_state_e;

  // Next-PC source.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module : fetch_pc
// Brief  : Program counter register with its next-PC mux.
//          sel = PC_HOLD keeps the PC, PC_INC adds one (wrapping modulo
//          2^PC_W), PC_LOAD takes the redirect target unmodified.
// Ports  : clk, reset (sync, active-high), sel (next-PC source),
//          target (redirect address), pc (current PC).
// Rev    : 1.0  initial release
// ============================================================================
module fetch_pc
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_sel_e         sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:  pc_d = pc_q + PC_W'(1);  // natural wrap at 2^PC_W
      PC_LOAD: pc_d = target;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch
// Brief  : Fetch stage plus IF/ID pipeline register. Reads a combinational
//          instruction memory at the current PC, registers the word and its
//          PC for the decoder, honours hazard stalls and EX-stage branch
//          redirects, and on the all-zero end-of-program word drains the
//          pipe with bubbles before raising done.
// Ports  : clk, reset (sync, active-high), start, stall, branch_taken,
//          branch_target, imem_addr/imem_data (instruction memory),
//          if_id_instr/if_id_pc/if_id_valid (to decode), pc, done.
// Rev    : 1.0  initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          PC_W         = 32,
  parameter int          IMEM_AW      = 8,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR    = instruction_fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = FETCH_IDLE;
  localparam logic [1:0] S_RUN   = FETCH_RUN;
  localparam logic [1:0] S_DRAIN = FETCH_DRAIN;
  localparam logic [1:0] S_DONE  = FETCH_DONE;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] ifpc_q, ifpc_d;
  logic            valid_q, valid_d;
  pc_sel_e         pc_sel;

  fetch_pc #(
    .PC_W (PC_W)
  ) u_fetch_pc (
    .clk    (clk),
    .reset  (reset),
    .sel    (pc_sel),
    .target (branch_target),
    .pc     (pc)
  );

  // Fetch address aliases modulo 2^IMEM_AW.
  assign imem_addr = pc[IMEM_AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    pc_sel  = PC_HOLD;

    case (state_q)
      S_IDLE: begin
        // Nothing is fetched in the start cycle; RUN begins next cycle.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall and over an end marker; the word
          // currently on imem_data is wrong-path and gets flushed.
          pc_sel  = PC_LOAD;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything (defaults).
        end else if (imem_data == 32'd0) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          pc_sel  = PC_INC;
          instr_d = imem_data;
          ifpc_d  = pc;
          valid_d = 1'b1;
        end
      end

      S_DRAIN: begin
        // Stall is ignored here: only bubbles are being issued.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (branch_taken) begin
          // An older branch still in flight resolved taken: resume fetch.
          pc_sel  = PC_LOAD;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        // DONE: terminal until reset.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire
